sqrt_iter: RTL and testbench

//   Parametrised fixed-point unsigned square root for the norm path; successor to the fixed Q-format Newton datapath/controller.

---
 rtl/norm_pkg.sv | 26 ++
 rtl/sqrt_step.sv | 25 ++
 rtl/sqrt_iter.sv | 112 +++++++++++
 tb/tb_sqrt_iter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/norm_pkg.sv
// Shared definitions for the vector-norm path: sqrt FSM states, iteration count
// and the parameter-legality check used by the norm blocks.
package norm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sqrt_state_t;

    function automatic int sqrt_iter_count(input int width, input int frac, input int bpc);
        return ((width + frac) / 2) / bpc;
    endfunction

    function automatic bit sqrt_params_ok(input int width, input int frac, input int bpc);
        bit ok;
        ok = 1'b1;
        if (width < 8 || (width % 2) != 0)        ok = 1'b0;
        if (frac < 0 || frac > width)              ok = 1'b0;
        if ((frac % 2) != 0)                       ok = 1'b0;
        if (bpc != 1 && bpc != 2)                  ok = 1'b0;
        if ((((width + frac) / 2) % bpc) != 0)     ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/sqrt_step.sv
// One non-restoring square-root digit: shifts two radicand bits into the
// partial remainder, adds or subtracts the trial term and appends one root bit.
module sqrt_step #(
    parameter int RB = 24
) (
    input  logic [RB+1:0] rem_in,
    input  logic [RB-1:0] root_in,
    input  logic [1:0]    rad_bits,
    output logic [RB+1:0] rem_out,
    output logic [RB-1:0] root_out
);

    logic [RB+1:0] shifted;

    always_comb begin
        shifted = {rem_in[RB-1:0], rad_bits};
        // Negative remainder: add {root,11} instead of restoring.
        if (rem_in[RB+1])
            rem_out = shifted + {root_in, 2'b11};
        else
            rem_out = shifted - {root_in, 2'b01};
        root_out = {root_in[RB-2:0], ~rem_out[RB+1]};
    end

endmodule

// File: rtl/sqrt_iter.sv
// Iterative fixed-point square root: floor(sqrt(DATA_IN)) in the same Q format,
// BPC root bits per cycle, valid/ready on both sides.
module sqrt_iter
    import norm_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int FRAC   = 16,
    parameter int BPC    = 1,
    parameter int SIGNED = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] DATA_IN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] DATA_OUT,
    output logic             EXACT,
    output logic             ERR,
    output logic             BUSY
);

    localparam int RW   = WIDTH + FRAC;
    localparam int RB   = RW / 2;
    localparam int ITER = sqrt_iter_count(WIDTH, FRAC, BPC);
    localparam int CW   = $clog2(ITER + 1);

    if (!sqrt_params_ok(WIDTH, FRAC, BPC) || (SIGNED != 0 && SIGNED != 1)) begin : g_param_check
        $error("sqrt_iter: illegal WIDTH/FRAC/BPC/SIGNED combination");
    end

    sqrt_state_t   state;
    logic [RW-1:0] rad_q;
    logic [RB+1:0] rem_q;
    logic [RB-1:0] root_q;
    logic [CW-1:0] cnt_q;
    logic          err_q;

    logic [RB+1:0] rem_c  [BPC+1];
    logic [RB-1:0] root_c [BPC+1];
    logic [RB+1:0] rem_fix;

    assign rem_c[0]  = rem_q;
    assign root_c[0] = root_q;

    for (genvar i = 0; i < BPC; i++) begin : g_step
        sqrt_step #(.RB(RB)) u_step (
            .rem_in   (rem_c[i]),
            .root_in  (root_c[i]),
            .rad_bits (rad_q[RW-1-2*i -: 2]),
            .rem_out  (rem_c[i+1]),
            .root_out (root_c[i+1])
        );
    end

    // Last digit may leave a negative remainder; add {root,1} to get the true one.
    assign rem_fix = rem_c[BPC][RB+1] ? rem_c[BPC] + {1'b0, root_c[BPC], 1'b1} : rem_c[BPC];

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state  <= IDLE;
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (IN_VALID) begin
                        rad_q  <= RW'(DATA_IN) << FRAC;
                        rem_q  <= '0;
                        root_q <= '0;
                        cnt_q  <= CW'(ITER - 1);
                        if (SIGNED != 0 && DATA_IN[WIDTH-1]) begin
                            err_q <= 1'b1;
                            state <= DONE;
                        end else begin
                            err_q <= 1'b0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rad_q  <= rad_q << (2 * BPC);
                    root_q <= root_c[BPC];
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        rem_q <= rem_fix;
                        state <= DONE;
                    end else begin
                        rem_q <= rem_c[BPC];
                    end
                end
                DONE: begin
                    if (OUT_READY)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign IN_READY  = (state == IDLE) && RST;
    assign OUT_VALID = (state == DONE);
    assign BUSY      = (state != IDLE);
    assign DATA_OUT  = (state == DONE && !err_q) ? WIDTH'(root_q) : '0;
    assign EXACT     = (state == DONE) && !err_q && (rem_q == '0);
    assign ERR       = (SIGNED != 0) && (state == DONE) && err_q;

endmodule

// File: tb/tb_sqrt_iter.sv
// Scoreboard bench for sqrt_iter: an unsigned BPC=1 instance and a signed BPC=2
// instance, checked against an integer-sqrt reference computed by bisection.
module tb_sqrt_iter;

    typedef struct {
        logic [31:0] q;
        logic        ex;
        logic        er;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst       [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [31:0] data_in   [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] data_out  [2];
    logic        exact     [2];
    logic        err       [2];
    logic        busy      [2];

    bit          hold      [2];
    bit          stall     [2];
    logic [31:0] prev_q    [2];
    logic        prev_ex   [2];
    logic        prev_er   [2];

    exp_t sb0[$];
    exp_t sb1[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sqrt_iter #(.WIDTH(32), .FRAC(16), .BPC(1), .SIGNED(0)) u_dut0 (
        .CLK(clk), .RST(rst[0]), .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]),
        .DATA_IN(data_in[0]), .OUT_VALID(out_valid[0]), .OUT_READY(out_ready[0]),
        .DATA_OUT(data_out[0]), .EXACT(exact[0]), .ERR(err[0]), .BUSY(busy[0])
    );

    sqrt_iter #(.WIDTH(32), .FRAC(16), .BPC(2), .SIGNED(1)) u_dut1 (
        .CLK(clk), .RST(rst[1]), .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]),
        .DATA_IN(data_in[1]), .OUT_VALID(out_valid[1]), .OUT_READY(out_ready[1]),
        .DATA_OUT(data_out[1]), .EXACT(exact[1]), .ERR(err[1]), .BUSY(busy[1])
    );

    // floor(sqrt(x * 2^16)) by bisection on 64-bit integers
    function automatic exp_t ref_model(input logic [31:0] x, input bit is_signed);
        exp_t e;
        longint unsigned r, lo, hi, mid;
        if (is_signed && x[31]) begin
            e.q = '0; e.ex = 1'b0; e.er = 1'b1;
            return e;
        end
        r  = longint'(x) << 16;
        lo = 0;
        hi = 64'd1 << 24;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= r) lo = mid;
            else                hi = mid;
        end
        e.q  = lo[31:0];
        e.ex = (lo * lo == r);
        e.er = 1'b0;
        return e;
    endfunction

    function automatic logic [31:0] rand_operand();
        int unsigned k;
        int unsigned r;
        k = $urandom_range(0, 3);
        case (k)
            0:       return $urandom;
            1:       return $urandom_range(0, 255);
            2:       begin r = $urandom_range(0, 65535); return r * r; end
            default: return $urandom | 32'h8000_0000;
        endcase
    endfunction

    function automatic int sb_size(input int d);
        return (d == 0) ? sb0.size() : sb1.size();
    endfunction

    task automatic sb_push(input int d, input exp_t e);
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    task automatic sb_pop(input int d, output bit ok, output exp_t e);
        ok = 1'b0;
        e  = '{q: '0, ex: 1'b0, er: 1'b0};
        if (d == 0 && sb0.size() > 0) begin e = sb0.pop_front(); ok = 1'b1; end
        if (d == 1 && sb1.size() > 0) begin e = sb1.pop_front(); ok = 1'b1; end
    endtask

    // Issue one operand; optionally measure edges from the accepting edge (inclusive) to OUT_VALID.
    task automatic send(input int d, input logic [31:0] x, input int want_lat);
        int n;
        int lat;
        data_in[d]  = x;
        in_valid[d] = 1'b1;
        n = 0;
        while (!in_ready[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[d]) begin
            checks++; errors++;
            $display("FAIL dut%0d accept_timeout: in_ready=%0b required 1", d, in_ready[d]);
            in_valid[d] = 1'b0;
            return;
        end
        sb_push(d, ref_model(x, d == 1));
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        data_in[d]  = $urandom;
        if (want_lat > 0) begin
            lat = 1;
            while (!out_valid[d] && lat < 200) begin
                @(posedge clk);
                #1;
                lat++;
            end
            checks++;
            if (lat != want_lat) begin
                errors++;
                $display("FAIL dut%0d latency x=%08h: got %0d cycles required %0d", d, x, lat, want_lat);
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while ((busy[d] || sb_size(d) > 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy[d] || sb_size(d) > 0) begin
            errors++;
            $display("FAIL dut%0d drain: busy=%0b pending=%0d required 0/0", d, busy[d], sb_size(d));
        end
    endtask

    task automatic check_idle_outputs(input int d, input logic want_ready, input string tag);
        checks++;
        if ({out_valid[d], busy[d], exact[d], err[d], data_out[d]} !== '0 || in_ready[d] !== want_ready) begin
            errors++;
            $display("FAIL dut%0d %s: valid=%0b busy=%0b exact=%0b err=%0b data=%08h ready=%0b required 0 0 0 0 00000000 %0b",
                     d, tag, out_valid[d], busy[d], exact[d], err[d], data_out[d], in_ready[d], want_ready);
        end
    endtask

    task automatic mon_step(input int d);
        exp_t e;
        bit   ok;
        if (!rst[d]) begin
            stall[d] = 1'b0;
            return;
        end
        if (!out_valid[d]) begin
            if (stall[d]) begin
                checks++; errors++;
                $display("FAIL dut%0d valid_dropped: out_valid=0 required 1 while stalled", d);
            end
            stall[d] = 1'b0;
            return;
        end
        checks++;
        if (in_ready[d] !== 1'b0) begin
            errors++;
            $display("FAIL dut%0d ready_in_done: in_ready=%0b required 0", d, in_ready[d]);
        end
        if (stall[d]) begin
            checks++;
            if (data_out[d] !== prev_q[d] || exact[d] !== prev_ex[d] || err[d] !== prev_er[d]) begin
                errors++;
                $display("FAIL dut%0d hold_stable: data=%08h exact=%0b err=%0b required %08h %0b %0b",
                         d, data_out[d], exact[d], err[d], prev_q[d], prev_ex[d], prev_er[d]);
            end
        end
        if (out_ready[d]) begin
            stall[d] = 1'b0;
            checks++;
            sb_pop(d, ok, e);
            if (!ok) begin
                errors++;
                $display("FAIL dut%0d unexpected_output: data=%08h with empty scoreboard", d, data_out[d]);
            end else if (data_out[d] !== e.q || exact[d] !== e.ex || err[d] !== e.er) begin
                errors++;
                $display("FAIL dut%0d result: data=%08h exact=%0b err=%0b required %08h %0b %0b",
                         d, data_out[d], exact[d], err[d], e.q, e.ex, e.er);
            end
        end else begin
            stall[d]   = 1'b1;
            prev_q[d]  = data_out[d];
            prev_ex[d] = exact[d];
            prev_er[d] = err[d];
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            stall[d] = 1'b0;
            prev_q[d] = '0; prev_ex[d] = 1'b0; prev_er[d] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) mon_step(d);
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) out_ready[d] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++)
                out_ready[d] = hold[d] ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0; in_valid[d] = 1'b0; data_in[d] = '0; hold[d] = 1'b0;
        end
        in_valid[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) check_idle_outputs(d, 1'b0, "reset_state");
        in_valid[0] = 1'b0;
        for (int d = 0; d < 2; d++) rst[d] = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) check_idle_outputs(d, 1'b1, "after_reset");
        @(negedge clk);

        send(0, 32'h0004_0000, 25);
        send(0, 32'h0002_0000, 25);
        send(0, 32'hFFFF_FFFF, 25);
        send(0, 32'h0000_0000, 25);
        send(0, 32'h0001_0000, 0);
        drain(0);

        send(1, 32'h0004_0000, 13);
        send(1, 32'h8000_0000, 1);
        send(1, 32'h0001_0000, 13);
        send(1, 32'h7FFF_FFFF, 13);
        drain(1);

        // Backpressure: hold OUT_READY low for 10 cycles while poking IN_VALID
        hold[0] = 1'b1;
        send(0, 32'h0003_0000, 25);
        for (int i = 0; i < 10; i++) begin
            in_valid[0] = 1'b1;
            data_in[0]  = $urandom;
            @(negedge clk);
        end
        in_valid[0] = 1'b0;
        checks++;
        if (out_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL dut0 stall_valid: out_valid=%0b required 1", out_valid[0]);
        end
        hold[0] = 1'b0;
        drain(0);

        // Reset in the middle of CALC drops the in-flight operand
        send(0, 32'h1234_5678, 0);
        repeat (4) @(negedge clk);
        rst[0] = 1'b0;
        @(posedge clk);
        #1;
        check_idle_outputs(0, 1'b0, "mid_reset");
        sb0.delete();
        @(negedge clk);
        rst[0] = 1'b1;
        #1;
        check_idle_outputs(0, 1'b1, "mid_reset_release");
        send(0, 32'h0009_0000, 25);
        drain(0);

        for (int i = 0; i < 800; i++) send(0, rand_operand(), 0);
        drain(0);
        for (int i = 0; i < 1600; i++) send(1, rand_operand(), 0);
        drain(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
